// File: rtl/toggle_handshake_rx_pkg.sv
// Shared definitions for the toggle-handshake receiver: FSM encoding and
// default parameter values.
package toggle_handshake_rx_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/toggle_handshake_rx_sync_ff.sv
// Single-bit multi-flop synchroniser with synchronous active-high reset to 0.
// Shared with the transmitter side, which uses it for the returning ack toggle.
module sync_ff
    import toggle_handshake_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiving end of a two-phase toggle link: detects each req_tgl flip, holds the
// captured word on a valid/ready port and flips ack_tgl once it is accepted.
module toggle_handshake_rx
    import toggle_handshake_rx_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tgl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              proto_err,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic              req_s;
    logic              req_seen_r;
    logic              state_r;
    logic              state_s;
    logic              capture_s;
    logic              accept_s;
    logic              viol_s;
    logic [DATA_W-1:0] data_r;
    logic              ack_r;
    logic              err_r;
    logic [CNT_W-1:0]  cnt_r;

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req_tgl),
        .q   (req_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s != req_seen_r) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output strobes; a flip seen while holding is a violation, never a capture.
    always_comb begin
        capture_s = 1'b0;
        accept_s  = 1'b0;
        viol_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                capture_s = (req_s != req_seen_r);
            end
            ST_HOLD: begin
                accept_s = out_ready;
                viol_s   = (req_s != req_seen_r);
            end
            default: begin
                capture_s = 1'b0;
                accept_s  = 1'b0;
                viol_s    = 1'b0;
            end
        endcase
    end

    // Datapath and status registers driven by the FSM strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_seen_r <= 1'b0;
            data_r     <= {DATA_W{1'b0}};
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            if (capture_s) begin
                data_r     <= data_in;
                req_seen_r <= req_s;
            end
            if (accept_s) begin
                ack_r <= ~ack_r;
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (viol_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign out_valid = (state_r == ST_HOLD);
    assign data_out  = data_r;
    assign ack_tgl   = ack_r;
    assign proto_err = err_r;
    assign xfer_cnt  = cnt_r;

endmodule
